// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_rx receiver slice.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_CLK_HZ       = 50_000_000;
  localparam int UART_BAUD         = 115200;
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake and error pulses of uart_rx; master is the receiver.
interface uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output data, data_valid, frame_err, overrun, parity_err,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, frame_err, overrun, parity_err,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle level 1.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a live parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic      clock50,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic           rx_s;
  logic           tick_s;
  logic           good_s;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic           par_bad_q, par_bad_d;
  logic           perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk (clock50),
    .rst (reset),
    .d   (rx),
    .q   (rx_s)
  );

  assign tick_s = (cnt_q == CNT_ZERO);

  // Next-state logic for the frame FSM, bit timing and the holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    good_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = BIT_LOAD;
            idx_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = BIT_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          par_bad_d = rx_s ^ even_parity(shift_q);
          cnt_d     = BIT_LOAD;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad_q;
          good_s = rx_s & ~par_bad_q;
`else
          good_s = rx_s;
`endif
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        // A break holds the line low; wait for it to return to idle.
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // A drain and a load in the same cycle is not an overrun.
    if (good_s && (!valid_q || bus.data_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (good_s) begin
      ovr_d = 1'b1;
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16: a driver queues expected
// events with their cycle, and a negedge monitor pops and compares them.
module tb_uart_rx;
  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int K_NONE = -1;
  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;
  localparam int K_PERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic data_ready = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  uart_rx_if bus ();
  assign bus.data_ready = data_ready;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clock50 (clk),
    .reset   (reset),
    .rx      (rx),
    .bus     (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input logic [7:0] val);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d val=%h at cycle %0d, required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%h cycle=%0d, required kind=%0d val=%h cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Called just after a posedge; the byte or flag appears 3+H+(FB-1)*N cycles later.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input int stop_low,
                            input int kind, input logic [7:0] val);
    if (kind != K_NONE) exp_q.push_back('{kind, val, cyc + 3 + H + (FB - 1) * N});
    rx = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (N) @(posedge clk);
      #1;
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (N) @(posedge clk);
    #1;
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low * N) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a new byte is presented when valid rises or follows an accepted byte.
  initial begin
    logic prev_valid;
    logic prev_hs;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (bus.data_valid && (!prev_valid || prev_hs)) check_ev(K_DATA, bus.data);
        if (bus.frame_err)  check_ev(K_FERR, 8'h00);
        if (bus.overrun)    check_ev(K_OVR, 8'h00);
        if (bus.parity_err) check_ev(K_PERR, 8'h00);
        prev_valid = bus.data_valid;
        prev_hs    = bus.data_valid & data_ready;
      end
    end
  end

  initial begin
    logic [7:0] b;
    idle(3);
    reset = 1'b0;
    idle(2);
    chk("reset_data", bus.data, 8'h00);
    chk("reset_valid", {7'd0, bus.data_valid}, 8'h00);
    chk("reset_frame_err", {7'd0, bus.frame_err}, 8'h00);
    chk("reset_overrun", {7'd0, bus.overrun}, 8'h00);
    chk("reset_parity_err", {7'd0, bus.parity_err}, 8'h00);

    send_frame(8'h40, 1'b0, 0, K_DATA, 8'h40);
    chk("single_valid_one_cycle", {7'd0, bus.data_valid}, 8'h00);
    chk("single_data_held", bus.data, 8'h40);
    idle(4);

    send_frame(8'h55, 1'b0, 0, K_DATA, 8'h55);
    send_frame(8'hAA, 1'b0, 0, K_DATA, 8'hAA);
    send_frame(8'h00, 1'b0, 0, K_DATA, 8'h00);
    idle(4);

    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(3 * N);
    chk("glitch_no_valid", {7'd0, bus.data_valid}, 8'h00);

    send_frame(8'h3C, 1'b0, 3, K_FERR, 8'h00);
    idle(4);
    send_frame(8'h81, 1'b0, 0, K_DATA, 8'h81);
    idle(4);

    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 0, K_DATA, 8'h11);
    send_frame(8'h22, 1'b0, 0, K_OVR, 8'h00);
    chk("overrun_data_kept", bus.data, 8'h11);
    chk("overrun_valid_held", {7'd0, bus.data_valid}, 8'h01);
    data_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid_before_edge", {7'd0, bus.data_valid}, 8'h01);
    @(posedge clk);
    #1;
    chk("drain_valid_cleared", {7'd0, bus.data_valid}, 8'h00);
    idle(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0, K_PERR, 8'h00);
    idle(4);
    send_frame(8'h07, 1'b0, 0, K_DATA, 8'h07);
    idle(4);
`endif

    data_ready = 1'b0;
    send_frame(8'h99, 1'b0, 0, K_DATA, 8'h99);
    b = 8'hE6;
    rx = 1'b0;
    idle(N);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(N);
    end
    rx = b[4];
    idle(H);
    reset = 1'b1;
    rx = 1'b1;
    #1;
    chk("midreset_data", bus.data, 8'h00);
    chk("midreset_valid", {7'd0, bus.data_valid}, 8'h00);
    chk("midreset_frame_err", {7'd0, bus.frame_err}, 8'h00);
    chk("midreset_overrun", {7'd0, bus.overrun}, 8'h00);
    chk("midreset_parity_err", {7'd0, bus.parity_err}, 8'h00);
    idle(3);
    reset = 1'b0;
    data_ready = 1'b1;
    idle(4);
    send_frame(8'h5A, 1'b0, 0, K_DATA, 8'h5A);
    idle(20);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the `clock50` domain. It recovers 8N1 frames (optionally 8E1) from the `rx` pin at 115200 baud and presents each byte through a one-entry valid/ready holding register. It is the receive end of the link driven by the team's UART transmitter, and feeds bytes to the control logic of the VGA design.

## Interface
- `CLKS_PER_BIT`, default 434: `clock50` cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `clock50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clock50`.
- `data`  out  8  received byte, valid while `data_valid` is high.
- `data_valid`  out  1  holding register full.
- `data_ready`  in  1  consumer accepts `data` on a `clock50` edge where `data_valid & data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while holding register full and not being drained.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- A down-counter of width $clog2(CLKS_PER_BIT) times each sample point. A 3-bit counter indexes the data bits, LSB first.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_IDLE.
  - IDLE: `rx_s==0` loads the counter with CLKS_PER_BIT/2−1 and moves to START.
  - START: at counter 0, sample `rx_s`. If 1, this is a false start: go to IDLE, no flags. If 0, go to DATA with the counter at CLKS_PER_BIT−1.
  - DATA: at each counter 0, shift `rx_s` into bit[idx] and reload the counter. After bit 7, go to PARITY or STOP.
  - PARITY: sample at counter 0 and compare with the XOR of the data bits (even parity). Go to STOP.
  - STOP: sample at counter 0.
    - If 1: the frame is good. Deliver the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s==1`, then go to IDLE. This covers the break condition.
- A parity mismatch pulses `parity_err` in the cycle after the stop sample. The byte is discarded, and the next state is chosen by the stop-bit rule above.
- Delivery into the holding register:
  - Register empty, or `data_ready` high that cycle: load `data` and set `data_valid`. No overrun in this case, including a simultaneous drain and load.
  - Register full and `data_ready` low: keep the old byte, drop the new one and pulse `overrun`.
- `data_valid` clears on the edge after a transfer unless a new byte loads in the same cycle.

## Timing
- Reset values:
  - `data`=0, `data_valid`=0, all error pulses 0.
  - FSM in IDLE, counters 0.
  - Synchronizer flops = 1.
- Reset mid-frame aborts the frame. No flags are raised.
- Let t0 be the first cycle `rx_s` is low in IDLE; `rx_s` lags the pin by 2 cycles. Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT.
  - Start sample: t0+H.
  - Data bit i: t0+H+(i+1)·N.
  - Stop sample: t0+H+9·N, or t0+H+10·N with parity.
- `data_valid` rises, or a flag pulses, one cycle after the stop sample.
- The FSM returns to IDLE in the cycle after a good stop sample, so back-to-back frames with one stop bit are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined: even parity bit expected between bit 7 and the stop bit, the PARITY state exists, and `parity_err` is live.
- Not defined: 8N1, no PARITY state, `parity_err` tied 0.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum.
  - `UART_CLK_HZ` = 50_000_000, `UART_BAUD` = 115200.
  - Default `CLKS_PER_BIT` derived from those two.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1.

## Test plan
- CLKS_PER_BIT=16, `data_ready`=1, frame 0x40 (8N1) → `data`=0x40 and `data_valid` high for 1 cycle at t0+H+9·N+1. No flags.
- 3 back-to-back frames 0x55, 0xAA, 0x00 with `data_ready`=1 → 3 deliveries in order. Spacing between deliveries is exactly 10·N cycles.
- 6-cycle low glitch on `rx` → FSM returns to IDLE, no `data_valid`, no flags.
- Frame 0x3C with the stop bit held low for 3 bit times → `frame_err` pulse, no delivery. A following 0x81 frame is received correctly after the line goes high.
- `data_ready`=0, frames 0x11 then 0x22 → `data` stays 0x11 and `overrun` pulses once. Asserting `data_ready` then clears `data_valid` on the next edge.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 → `parity_err` pulse, no delivery. 0x07 sent with parity bit 1 → delivered. Separately, assert `reset` in the middle of bit 4 → all outputs return to reset values and the next frame is received cleanly.
